// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the snooping-bus controller: bus ops, controller states
// and fill-data source select values.
package snoop_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      BUS_RD_MISS = 2'b00,
      BUS_WR_MISS = 2'b01,
      BUS_UPGRADE = 2'b10
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      RESP,
      FORWARD,
      MEM,
      DONE
   } bus_state_t;

   localparam logic SRC_MEM  = 1'b0;
   localparam logic SRC_PEER = 1'b1;

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Core/memory side of the snooping bus. The controller uses the master view;
// caches and the memory port use the slave view.
interface snoop_bus_ctrl_if
   import snoop_bus_ctrl_pkg::*;
#(
   parameter int NUM_CPU = 2,
   parameter int ADDR_W  = 5
) ();
   localparam int ID_W = $clog2(NUM_CPU);

   logic [NUM_CPU-1:0]             req_valid;
   logic [NUM_CPU-1:0][1:0]        req_op;
   logic [NUM_CPU-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_CPU-1:0]             grant;
   logic                           snoop_valid;
   bus_op_t                        snoop_op;
   logic [ADDR_W-1:0]              snoop_addr;
   logic [NUM_CPU-1:0]             snoop_en;
   logic [NUM_CPU-1:0]             snoop_hit;
   logic [NUM_CPU-1:0]             fwd_sel;
   logic [ID_W-1:0]                fwd_src;
   logic                           mem_rd_req;
   logic                           mem_ack;
   logic [NUM_CPU-1:0]             done;

   modport master (
      input  req_valid, req_op, req_addr, snoop_hit, mem_ack,
      output grant, snoop_valid, snoop_op, snoop_addr, snoop_en,
             fwd_sel, fwd_src, mem_rd_req, done
   );

   modport slave (
      output req_valid, req_op, req_addr, snoop_hit, mem_ack,
      input  grant, snoop_valid, snoop_op, snoop_addr, snoop_en,
             fwd_sel, fwd_src, mem_rd_req, done
   );

endinterface

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping modulo NUM_CPU.
module rr_arbiter #(
   parameter int NUM_CPU = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_CPU-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   input  logic               en,
   output logic               any_req,
   output logic [ID_W-1:0]    winner,
   output logic [NUM_CPU-1:0] gnt
);

   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      gnt     = '0;
      for (int i = 0; i < NUM_CPU; i++) begin
         int idx;
         idx = (int'(rr_ptr) + i) % NUM_CPU;
         if (en && req[idx] && !any_req) begin
            any_req = 1'b1;
            winner  = ID_W'(idx);
         end
      end
      if (any_req) gnt[winner] = 1'b1;
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller: round-robin arbitration, snoop broadcast, hit
// collection and fill routing from a peer cache or from memory.
module snoop_bus_ctrl
   import snoop_bus_ctrl_pkg::*;
#(
   parameter int NUM_CPU  = 2,
   parameter int ADDR_W   = 5,
   parameter int FWD_HOLD = 2
) (
   input  logic              clk,
   input  logic              rst,
   snoop_bus_ctrl_if.master  bus
);
   localparam int ID_W = $clog2(NUM_CPU);

   bus_state_t         state_q, state_d;
   logic [ID_W-1:0]    win_q, rr_ptr_q, src_q, arb_win, hit_id;
   bus_op_t            op_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [3:0]         cnt_q;
   logic [NUM_CPU-1:0] grant_q, arb_gnt, hit_vec;
   logic               any_req, hit_any;

   rr_arbiter #(.NUM_CPU(NUM_CPU), .ID_W(ID_W)) u_arb (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr_q),
      .en      (state_q == IDLE),
      .any_req (any_req),
      .winner  (arb_win),
      .gnt     (arb_gnt)
   );

   // Requester's own hit is masked; lowest-index remaining hitter supplies data.
   always_comb begin
      hit_vec = bus.snoop_hit & ~grant_q;
      hit_any = |hit_vec;
      hit_id  = '0;
      for (int i = NUM_CPU - 1; i >= 0; i--)
         if (hit_vec[i]) hit_id = ID_W'(i);
   end

   assign bus.grant = grant_q;

   always_comb begin
      state_d         = state_q;
      bus.snoop_valid = 1'b0;
      bus.snoop_op    = BUS_RD_MISS;
      bus.snoop_addr  = '0;
      bus.snoop_en    = '0;
      bus.fwd_sel     = '0;
      bus.fwd_src     = '0;
      bus.mem_rd_req  = 1'b0;
      bus.done        = '0;
      case (state_q)
         IDLE:    if (any_req) state_d = SNOOP;
         SNOOP: begin
            bus.snoop_valid = 1'b1;
            bus.snoop_op    = op_q;
            bus.snoop_addr  = addr_q;
            bus.snoop_en    = ~grant_q;
            state_d         = RESP;
         end
         // Upgrades only need the invalidating snoop; other holders' hits are moot.
         RESP: begin
            if (op_q == BUS_UPGRADE) state_d = DONE;
            else if (hit_any)        state_d = FORWARD;
            else                     state_d = MEM;
         end
         FORWARD: begin
            for (int i = 0; i < NUM_CPU; i++)
               bus.fwd_sel[i] = grant_q[i] ? SRC_PEER : SRC_MEM;
            bus.fwd_src = src_q;
            if (cnt_q == 4'(FWD_HOLD - 1)) state_d = DONE;
         end
         MEM: begin
            bus.mem_rd_req = 1'b1;
            if (bus.mem_ack) state_d = DONE;
         end
         DONE: begin
            bus.done = grant_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         win_q    <= '0;
         op_q     <= BUS_RD_MISS;
         addr_q   <= '0;
         rr_ptr_q <= '0;
         src_q    <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (any_req) begin
               win_q   <= arb_win;
               grant_q <= arb_gnt;
               op_q    <= bus_op_t'(bus.req_op[arb_win]);
               addr_q  <= bus.req_addr[arb_win];
            end
            RESP: begin
               src_q <= hit_id;
               cnt_q <= '0;
            end
            FORWARD: cnt_q <= cnt_q + 4'd1;
            DONE: begin
               grant_q  <= '0;
               rr_ptr_q <= (win_q == ID_W'(NUM_CPU - 1)) ? '0 : win_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: each issued request pushes its expected
// snoop/fill/latency record, checked when the controller serves it.
module tb_snoop_bus_ctrl;
   import snoop_bus_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int FH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snoop_bus_ctrl_if #(.NUM_CPU(N), .ADDR_W(AW)) bus ();

   snoop_bus_ctrl #(.NUM_CPU(N), .ADDR_W(AW), .FWD_HOLD(FH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int            id;
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [N-1:0]  hit;
      bit            fwd;
      int            src;
      bit            mem;
      int            mdly;
      int            lat;
      int            start;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_err = 0, cyc = 0, mem_dly = 3;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Expected outcome per request: upgrades finish after the snoop, misses
   // take data from the lowest other hitter, else from memory.
   task automatic issue(input int id, input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [N-1:0] hit, input bit lat_chk);
      exp_t e;
      logic [N-1:0] h;
      e.id = id; e.op = op; e.addr = addr; e.hit = hit;
      e.fwd = 0; e.src = 0; e.mem = 0; e.mdly = mem_dly; e.start = cyc;
      h = hit & ~(N'(1) << id);
      if (op != BUS_UPGRADE) begin
         if (h != '0) begin
            e.fwd = 1;
            for (int i = N - 1; i >= 0; i--) if (h[i]) e.src = i;
         end else e.mem = 1;
      end
      e.lat = !lat_chk ? 0 : e.fwd ? 4 + FH : e.mem ? 4 + mem_dly : 4;
      sb.push_back(e);
      bus.req_op[id]    = op;
      bus.req_addr[id]  = addr;
      bus.req_valid[id] = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   // Plays the caches and memory, and compares everything the controller emits.
   task automatic monitor();
      exp_t e;
      logic [N-1:0] oh, en_exp;
      int fcnt = 0, mcnt = 0;
      bit keep = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            fcnt = 0; mcnt = 0; keep = 0;
            bus.snoop_hit = '0;
            bus.mem_ack   = 1'b0;
         end else begin
            if (bus.snoop_valid) begin
               if (sb.size() == 0) chk("snoop_unexp", bus.snoop_valid, 0);
               else begin
                  e = sb[0];
                  oh = N'(1) << e.id;
                  en_exp = ~oh;
                  chk("grant", bus.grant, oh);
                  chk("snoop_en", bus.snoop_en, en_exp);
                  chk("snoop_addr", bus.snoop_addr, e.addr);
                  chk("snoop_op", 32'(bus.snoop_op), e.op);
                  bus.snoop_hit = e.hit;
                  keep = 1; fcnt = 0; mcnt = 0;
               end
            end else if (keep) keep = 0;
            else bus.snoop_hit = '0;

            if (|bus.fwd_sel) begin
               fcnt++;
               oh = N'(1) << e.id;
               chk("fwd_sel", bus.fwd_sel, oh);
               chk("fwd_src", bus.fwd_src, e.src);
            end

            if (bus.mem_rd_req) begin
               mcnt++;
               chk("mem_fwd_sel", bus.fwd_sel, 0);
               bus.mem_ack = (mcnt == mem_dly);
            end else bus.mem_ack = 1'b0;

            if (|bus.done) begin
               if (sb.size() == 0) chk("done_unexp", bus.done, 0);
               else begin
                  e = sb.pop_front();
                  oh = N'(1) << e.id;
                  chk("done", bus.done, oh);
                  chk("fwd_cycles", fcnt, e.fwd ? FH : 0);
                  chk("mem_cycles", mcnt, e.mem ? e.mdly : 0);
                  if (e.lat != 0) chk("latency", cyc - e.start, e.lat);
                  bus.req_valid[e.id] = 1'b0;
               end
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_addr  = '0;
      bus.snoop_hit = '0;
      bus.mem_ack   = 1'b0;
      fork monitor(); join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", bus.grant, 0);
      chk("rst_snoop_valid", bus.snoop_valid, 0);
      chk("rst_snoop_en", bus.snoop_en, 0);
      chk("rst_fwd_sel", bus.fwd_sel, 0);
      chk("rst_mem_rd_req", bus.mem_rd_req, 0);
      chk("rst_done", bus.done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // peer forward, then memory fill, then an upgrade that brings rr_ptr to 0
      issue(2, BUS_RD_MISS, 5'h0A, 4'b1000, 1); drain();
      issue(0, BUS_RD_MISS, 5'h11, 4'b0000, 1); drain();
      issue(3, BUS_UPGRADE, 5'h03, 4'b0111, 1); drain();

      // all cores at once: served 0,1,2,3
      issue(0, BUS_UPGRADE, 5'h01, 4'b0000, 1);
      issue(1, BUS_RD_MISS, 5'h02, 4'b0001, 0);
      issue(2, BUS_WR_MISS, 5'h03, 4'b0000, 0);
      issue(3, BUS_UPGRADE, 5'h04, 4'b1111, 0);
      drain();

      // pointer wrapped to 0: core 1 must beat core 3
      issue(1, BUS_UPGRADE, 5'h07, 4'b1101, 1);
      issue(3, BUS_RD_MISS, 5'h08, 4'b0000, 0);
      drain();

      // requester's own hit must not win the forward
      issue(0, BUS_RD_MISS, 5'h15, 4'b1001, 1); drain();

      // reset while waiting on memory; request survives and is re-arbitrated
      mem_dly = 10;
      issue(1, BUS_RD_MISS, 5'h1F, 4'b0000, 0);
      begin
         int t = 0;
         while (!bus.mem_rd_req && t < 20) begin
            @(posedge clk); #1;
            t++;
         end
      end
      chk("mem_req_seen", bus.mem_rd_req, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_grant", bus.grant, 0);
      chk("midrst_mem_rd_req", bus.mem_rd_req, 0);
      chk("midrst_fwd_sel", bus.fwd_sel, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_snoop_valid", bus.snoop_valid, 0);
      sb.delete();
      mem_dly = 3;
      @(posedge clk); #1;
      rst = 1'b0;
      issue(1, BUS_RD_MISS, 5'h1F, 4'b0000, 1); drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
